irs_lock_scheduler: RTL and testbench
=====================================

Name: irs_lock_scheduler

Overview:
Sequences block lock/unlock/free traffic into the IRS block manager's lock and free handshake ports. It arbitrates between two requesters: the trigger path, which locks a block, and the readout path, which releases a block by unlocking it and then freeing it. It guarantees one manager transaction at a time, mutually exclusive lock/unlock, and one counted transaction per request. It also tracks the number of outstanding locked blocks and flags handshake timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for a manager ack before aborting a handshake
MAX_LOCKED, 511, outstanding-lock ceiling; lock grants are held off at this value

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active high
enable_i  in  1  allow new grants
trig_req_i  in  1  trigger lock request (level)
trig_addr_i  in  9  block to lock
trig_ack_o  out  1  1-cycle done pulse to trigger path
rd_req_i  in  1  readout release request (level)
rd_addr_i  in  9  block to release
rd_ack_o  out  1  1-cycle done pulse to readout path
lock_address_o  out  9  to manager lock_address_i
lock_o  out  1  to manager lock_i
unlock_o  out  1  to manager unlock_i
lock_strobe_o  out  1  to manager lock_strobe_i
lock_ack_i  in  1  from manager lock_ack_o
free_address_o  out  9  to manager free_address_i
free_strobe_o  out  1  to manager free_strobe_i
free_ack_i  in  1  from manager free_ack_o
outstanding_o  out  9  locked-block count
full_o  out  1  outstanding_o == MAX_LOCKED
busy_o  out  1  FSM not IDLE
timeout_o  out  1  sticky handshake timeout
underflow_o  out  1  sticky release-at-zero
err_clear_i  in  1  clears timeout_o and underflow_o
debug_o  out  8  [3:0] state, [4] last_grant, [5] full, [6] timeout, [7] underflow

Behaviour:
- All outputs are registered. On rst_i, every output is 0, the FSM goes to IDLE, last_grant=readout, and the counter is 0. Reset mid-handshake drops the strobes on the next cycle; requesters must re-request.
- Requester rule: req is held high with a stable address until its ack pulse. req low without an ack is a protocol violation; the scheduler finishes the transaction anyway.
- Arbitration in IDLE, only when enable_i=1:
  - trig_req is eligible only if !full_o; rd_req is always eligible.
  - If both are eligible, grant the requester other than last_grant (round-robin); update last_grant on grant.
  - Address is latched at grant.
- States: IDLE, LOCK_STB, UNLOCK_STB, FREE_STB, DONE.
  - LOCK_STB: lock_o=1, unlock_o=0, lock_strobe_o=1 until lock_ack_i is sampled high, then strobe drops next cycle -> DONE.
  - UNLOCK_STB: lock_o=0, unlock_o=1, same handshake -> FREE_STB.
  - FREE_STB: free_strobe_o=1 until free_ack_i is sampled high -> DONE.
  - DONE: 1-cycle ack to the granted requester; lock/unlock/strobes low -> IDLE.
  - Minimum latency from grant to ack: lock 3 cycles, release 5 cycles.
- Handshake shape: strobe is high for exactly the cycle of issue plus the cycle ack is seen (2 cycles typical). The manager counts one event per strobe rising, so a strobe is never re-asserted while ack is high.
- lock_o and unlock_o are never both high. Both are 0 outside a strobe.
- Timeout: a per-handshake counter reaches TIMEOUT_CYCLES with no ack ->
  - drop the strobe and set timeout_o;
  - skip remaining steps (an unlock timeout skips the free) -> DONE;
  - the requester is still acked and the counter is not changed.
- Counter:
  - +1 on a lock completing with ack.
  - -1 on an unlock completing with ack, if nonzero; if zero, stays 0 and underflow_o is set.
  - Never exceeds MAX_LOCKED because grants are gated.
- Errors: err_clear_i clears timeout_o/underflow_o; a simultaneous set wins.
- enable_i low mid-transaction: the current transaction completes, then no new grants. Pending reqs are held.

Decomposition:
- Package irs_lock_pkg: state encoding (4-bit, matching debug_o[3:0]), GRANT_TRIG/GRANT_RD constants, TIMEOUT_CYCLES and MAX_LOCKED defaults.
- One natural sub-module, irs_lock_handshake: single strobe/ack engine with timeout. It is instantiated once and shared for lock/unlock; the free handshake reuses it via a mux.

Test Plan:
- Trig lock addr 0x05 with manager-like ack model -> lock_o=1, strobe 2 cycles, trig_ack 3 cycles after grant, outstanding_o 0->1.
- Simultaneous trig and rd reqs, last_grant=readout -> trig served first, rd next; grants alternate over 4 rounds.
- Release addr 0x05 with outstanding=1 -> unlock handshake then free handshake with free_address_o=0x05, rd_ack once, outstanding 1->0, unlock_o never concurrent with lock_o.
- Ack input held low -> strobe drops after 255 cycles, timeout_o=1, requester acked, count unchanged; err_clear_i -> timeout_o=0.
- MAX_LOCKED=2, three trig locks -> third held off with full_o=1 until a release completes, then granted.
- Release at outstanding=0 -> manager handshakes performed, underflow_o=1, count stays 0; rst_i mid-LOCK_STB -> all outputs 0 next cycle.

Source files
------------

// File: rtl/irs_lock_pkg.sv
// rtl/irs_lock_pkg.sv - state encoding, grant ids and default limits for the IRS lock scheduler
package irs_lock_pkg;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_LOCK_STB   = 4'd1,
      ST_UNLOCK_STB = 4'd2,
      ST_FREE_STB   = 4'd3,
      ST_DONE       = 4'd4
   } state_t;

   localparam logic GRANT_TRIG = 1'b0;
   localparam logic GRANT_RD   = 1'b1;

   localparam int TIMEOUT_CYCLES_DEFAULT = 255;
   localparam int MAX_LOCKED_DEFAULT     = 511;

endpackage

// File: rtl/irs_lock_handshake.sv
// rtl/irs_lock_handshake.sv - single strobe/ack engine with timeout, steered to the lock or free port
module irs_lock_handshake
   import irs_lock_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic sel_free,
   input  logic lock_ack,
   input  logic free_ack,
   output logic lock_strobe,
   output logic free_strobe,
   output logic done,
   output logic timed_out
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt;
   logic        active;
   logic        ack;

   assign active    = lock_strobe | free_strobe;
   assign ack       = free_strobe ? free_ack : lock_ack;
   assign done      = active & ack;
   assign timed_out = active & ~ack & (wait_cnt == WAIT_LAST);

   // start wins over done so an unlock can hand straight over to the free strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_strobe <= 1'b0;
         free_strobe <= 1'b0;
         wait_cnt    <= '0;
      end else if (start) begin
         lock_strobe <= ~sel_free;
         free_strobe <= sel_free;
         wait_cnt    <= '0;
      end else if (done || timed_out) begin
         lock_strobe <= 1'b0;
         free_strobe <= 1'b0;
      end else if (active) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/irs_lock_scheduler.sv
// rtl/irs_lock_scheduler.sv - arbitrates trigger locks and readout releases onto the block manager ports
module irs_lock_scheduler
   import irs_lock_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int MAX_LOCKED     = MAX_LOCKED_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       trig_req_i,
   input  logic [8:0] trig_addr_i,
   output logic       trig_ack_o,
   input  logic       rd_req_i,
   input  logic [8:0] rd_addr_i,
   output logic       rd_ack_o,
   output logic [8:0] lock_address_o,
   output logic       lock_o,
   output logic       unlock_o,
   output logic       lock_strobe_o,
   input  logic       lock_ack_i,
   output logic [8:0] free_address_o,
   output logic       free_strobe_o,
   input  logic       free_ack_i,
   output logic [8:0] outstanding_o,
   output logic       full_o,
   output logic       busy_o,
   output logic       timeout_o,
   output logic       underflow_o,
   input  logic       err_clear_i,
   output logic [7:0] debug_o
);

   localparam logic [8:0] MAX_CNT = 9'(MAX_LOCKED);

   state_t     state;
   state_t     state_next;
   logic       last_grant;
   logic       last_grant_next;
   logic       trig_ok;
   logic       grant_trig;
   logic       grant_rd;
   logic       hs_start;
   logic       hs_sel_free;
   logic       hs_done;
   logic       hs_timeout;
   logic [8:0] lock_address_next;
   logic [8:0] free_address_next;
   logic [8:0] outstanding_next;
   logic       full_next;
   logic       timeout_next;
   logic       underflow_next;
   logic       lock_next;
   logic       unlock_next;
   logic       trig_ack_next;
   logic       rd_ack_next;
   logic       busy_next;
   logic [7:0] debug_next;

   assign trig_ok = trig_req_i & ~full_o;

   irs_lock_handshake #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_handshake (
      .clk        (clk_i),
      .rst        (rst_i),
      .start      (hs_start),
      .sel_free   (hs_sel_free),
      .lock_ack   (lock_ack_i),
      .free_ack   (free_ack_i),
      .lock_strobe(lock_strobe_o),
      .free_strobe(free_strobe_o),
      .done       (hs_done),
      .timed_out  (hs_timeout)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         last_grant     <= GRANT_RD;
         lock_address_o <= '0;
         free_address_o <= '0;
         outstanding_o  <= '0;
         full_o         <= 1'b0;
         timeout_o      <= 1'b0;
         underflow_o    <= 1'b0;
         lock_o         <= 1'b0;
         unlock_o       <= 1'b0;
         trig_ack_o     <= 1'b0;
         rd_ack_o       <= 1'b0;
         busy_o         <= 1'b0;
         debug_o        <= '0;
      end else begin
         state          <= state_next;
         last_grant     <= last_grant_next;
         lock_address_o <= lock_address_next;
         free_address_o <= free_address_next;
         outstanding_o  <= outstanding_next;
         full_o         <= full_next;
         timeout_o      <= timeout_next;
         underflow_o    <= underflow_next;
         lock_o         <= lock_next;
         unlock_o       <= unlock_next;
         trig_ack_o     <= trig_ack_next;
         rd_ack_o       <= rd_ack_next;
         busy_o         <= busy_next;
         debug_o        <= debug_next;
      end
   end

   // Round-robin only matters when both are eligible; a full counter hides the trigger
   always_comb begin
      grant_trig = 1'b0;
      grant_rd   = 1'b0;
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (enable_i) begin
               if (trig_ok && rd_req_i) begin
                  grant_trig = (last_grant == GRANT_RD);
                  grant_rd   = (last_grant == GRANT_TRIG);
               end else begin
                  grant_trig = trig_ok;
                  grant_rd   = rd_req_i;
               end
            end
            if (grant_trig)    state_next = ST_LOCK_STB;
            else if (grant_rd) state_next = ST_UNLOCK_STB;
         end
         ST_LOCK_STB: begin
            if (hs_done || hs_timeout) state_next = ST_DONE;
         end
         ST_UNLOCK_STB: begin
            if (hs_timeout)   state_next = ST_DONE;
            else if (hs_done) state_next = ST_FREE_STB;
         end
         ST_FREE_STB: begin
            if (hs_done || hs_timeout) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      last_grant_next   = last_grant;
      lock_address_next = lock_address_o;
      free_address_next = free_address_o;
      if (grant_trig) begin
         last_grant_next   = GRANT_TRIG;
         lock_address_next = trig_addr_i;
      end else if (grant_rd) begin
         last_grant_next   = GRANT_RD;
         lock_address_next = rd_addr_i;
         free_address_next = rd_addr_i;
      end

      hs_start    = grant_trig | grant_rd | ((state == ST_UNLOCK_STB) && (state_next == ST_FREE_STB));
      hs_sel_free = (state_next == ST_FREE_STB);

      // a set in the same cycle as err_clear_i must survive the clear
      outstanding_next = outstanding_o;
      underflow_next   = underflow_o & ~err_clear_i;
      timeout_next     = (timeout_o & ~err_clear_i) | hs_timeout;
      if (hs_done && (state == ST_LOCK_STB)) begin
         outstanding_next = outstanding_o + 9'd1;
      end
      if (hs_done && (state == ST_UNLOCK_STB)) begin
         if (outstanding_o != '0) outstanding_next = outstanding_o - 9'd1;
         else                     underflow_next   = 1'b1;
      end
      full_next = (outstanding_next == MAX_CNT);

      lock_next     = (state_next == ST_LOCK_STB);
      unlock_next   = (state_next == ST_UNLOCK_STB);
      trig_ack_next = (state_next == ST_DONE) && (last_grant_next == GRANT_TRIG);
      rd_ack_next   = (state_next == ST_DONE) && (last_grant_next == GRANT_RD);
      busy_next     = (state_next != ST_IDLE);
      debug_next    = {underflow_next, timeout_next, full_next, last_grant_next, state_next};
   end

endmodule

// File: tb/tb_irs_lock_scheduler.sv
// tb/tb_irs_lock_scheduler.sv - directed vector bench for irs_lock_scheduler with a registered manager model
module tb_irs_lock_scheduler;

   typedef struct {
      logic       is_rd;
      logic [8:0] addr;
      logic       ack_en;
      logic       clr;
      int         lat;
      int         lstb;
      int         fstb;
      int         cnt;
      logic       to;
      logic       uf;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b1;
   logic       trig_req = 1'b0;
   logic [8:0] trig_addr = '0;
   logic       rd_req = 1'b0;
   logic [8:0] rd_addr = '0;
   logic       lock_ack = 1'b0;
   logic       free_ack = 1'b0;
   logic       err_clear = 1'b0;
   logic       trig_ack_o, rd_ack_o, lock_o, unlock_o, lock_strobe_o, free_strobe_o;
   logic       full_o, busy_o, timeout_o, underflow_o;
   logic [8:0] lock_address_o, free_address_o, outstanding_o;
   logic [7:0] debug_o;
   logic [44:0] all_out;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic ack_en = 1'b1;
   logic lseen = 1'b0;
   logic fseen = 1'b0;
   int   lstb_cnt, fstb_cnt, lock_cnt, unlock_cnt, tack_cnt, rack_cnt;
   logic [8:0] last_laddr, last_faddr;
   logic rule_bad = 1'b0;
   int   ack_log[$];
   vec_t vecs[7];
   vec_t v;
   int   rq, ak, ts, ta, rs, ra;

   irs_lock_scheduler #(
      .TIMEOUT_CYCLES(255),
      .MAX_LOCKED    (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (enable),
      .trig_req_i    (trig_req),
      .trig_addr_i   (trig_addr),
      .trig_ack_o    (trig_ack_o),
      .rd_req_i      (rd_req),
      .rd_addr_i     (rd_addr),
      .rd_ack_o      (rd_ack_o),
      .lock_address_o(lock_address_o),
      .lock_o        (lock_o),
      .unlock_o      (unlock_o),
      .lock_strobe_o (lock_strobe_o),
      .lock_ack_i    (lock_ack),
      .free_address_o(free_address_o),
      .free_strobe_o (free_strobe_o),
      .free_ack_i    (free_ack),
      .outstanding_o (outstanding_o),
      .full_o        (full_o),
      .busy_o        (busy_o),
      .timeout_o     (timeout_o),
      .underflow_o   (underflow_o),
      .err_clear_i   (err_clear),
      .debug_o       (debug_o)
   );

   assign all_out = {lock_address_o, lock_o, unlock_o, lock_strobe_o, free_address_o, free_strobe_o,
                     outstanding_o, full_o, busy_o, timeout_o, underflow_o, debug_o, trig_ack_o, rd_ack_o};

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor plus manager model: ack one cycle after the strobe is first seen, for one cycle
   initial forever begin
      @(negedge clk);
      if (lock_strobe_o) begin lstb_cnt++; last_laddr = lock_address_o; end
      if (free_strobe_o) begin fstb_cnt++; last_faddr = free_address_o; end
      if (lock_o) lock_cnt++;
      if (unlock_o) unlock_cnt++;
      if ((lock_o && unlock_o) || ((lock_o || unlock_o) && !lock_strobe_o)) rule_bad = 1'b1;
      if (trig_ack_o) begin tack_cnt++; ack_log.push_back(0); end
      if (rd_ack_o) begin rack_cnt++; ack_log.push_back(1); end
      lock_ack = ack_en && lock_strobe_o && lseen && !lock_ack;
      lseen    = lock_strobe_o;
      free_ack = ack_en && free_strobe_o && fseen && !free_ack;
      fseen    = free_strobe_o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL %s: outputs %h expected all zero", name, all_out);
      end
   endtask

   task automatic clr_mon();
      lstb_cnt = 0; fstb_cnt = 0; lock_cnt = 0; unlock_cnt = 0;
      tack_cnt = 0; rack_cnt = 0;
      last_laddr = '0; last_faddr = '0;
      ack_log.delete();
   endtask

   task automatic do_req(input logic is_rd, input logic [8:0] addr, output int req_cyc, output int ack_cyc);
      bit got;
      got = 1'b0;
      ack_cyc = -1;
      if (is_rd) begin rd_addr = addr; rd_req = 1'b1; end
      else begin trig_addr = addr; trig_req = 1'b1; end
      req_cyc = cyc;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         if (is_rd ? rd_ack_o : trig_ack_o) begin got = 1'b1; ack_cyc = cyc; end
      end
      if (is_rd) rd_req = 1'b0;
      else trig_req = 1'b0;
      @(negedge clk);
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ack_wait: no ack for %s addr %0h within 2000 cycles", is_rd ? "readout" : "trigger", addr);
      end
   endtask

   initial begin
      //               is_rd  addr    ack_en clr   lat  lstb fstb cnt to    uf
      vecs[0] = '{1'b0, 9'h005, 1'b1, 1'b0,   3,   2,   0,  1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 9'h005, 1'b1, 1'b0,   5,   2,   2,  0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 9'h00A, 1'b1, 1'b0,   5,   2,   2,  0, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 9'h1FF, 1'b1, 1'b0,   3,   2,   0,  1, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 9'h1FF, 1'b1, 1'b1,   5,   2,   2,  0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 9'h033, 1'b0, 1'b0, 256, 255,   0,  0, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 9'h044, 1'b0, 1'b1, 256, 255,   0,  0, 1'b1, 1'b0};

      clr_mon();
      repeat (3) @(negedge clk);
      chk_zero("reset_outputs");
      rst = 1'b0;
      @(negedge clk);
      chk("reset_debug", debug_o, 8'h10);
      chk("reset_busy", busy_o, 0);

      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         if (v.clr) begin
            err_clear = 1'b1;
            @(negedge clk);
            err_clear = 1'b0;
         end
         ack_en = v.ack_en;
         clr_mon();
         do_req(v.is_rd, v.addr, rq, ak);
         chk($sformatf("v%0d_latency", i), ak - rq, v.lat);
         chk($sformatf("v%0d_lock_strobe_cycles", i), lstb_cnt, v.lstb);
         chk($sformatf("v%0d_lock_level_cycles", i), lock_cnt, v.is_rd ? 0 : v.lstb);
         chk($sformatf("v%0d_unlock_level_cycles", i), unlock_cnt, v.is_rd ? v.lstb : 0);
         chk($sformatf("v%0d_free_strobe_cycles", i), fstb_cnt, v.fstb);
         chk($sformatf("v%0d_outstanding", i), outstanding_o, v.cnt);
         chk($sformatf("v%0d_timeout", i), timeout_o, v.to);
         chk($sformatf("v%0d_underflow", i), underflow_o, v.uf);
         chk($sformatf("v%0d_trig_acks", i), tack_cnt, v.is_rd ? 0 : 1);
         chk($sformatf("v%0d_rd_acks", i), rack_cnt, v.is_rd ? 1 : 0);
         chk($sformatf("v%0d_lock_address", i), last_laddr, v.addr);
         if (v.fstb > 0) chk($sformatf("v%0d_free_address", i), last_faddr, v.addr);
      end
      chk("lock_unlock_rule", rule_bad, 0);

      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      chk("err_clear_timeout", timeout_o, 0);

      // Both requesters held with last_grant=readout: trigger first, then alternate
      ack_en = 1'b1;
      clr_mon();
      fork
         repeat (2) do_req(1'b0, 9'h011, ts, ta);
         repeat (2) do_req(1'b1, 9'h011, rs, ra);
      join
      chk("rr_ack_count", ack_log.size(), 4);
      for (int i = 0; i < ack_log.size() && i < 4; i++)
         chk($sformatf("rr_order%0d", i), ack_log[i], i % 2);
      chk("rr_outstanding", outstanding_o, 0);
      chk("rr_underflow", underflow_o, 0);

      trig_req  = 1'b1;
      trig_addr = 9'h077;
      @(negedge clk);
      chk("midrst_in_lock_strobe", lock_strobe_o, 1);
      rst      = 1'b1;
      trig_req = 1'b0;
      @(negedge clk);
      chk_zero("midrst_outputs");
      rst = 1'b0;
      @(negedge clk);

      enable = 1'b0;
      fork
         do_req(1'b0, 9'h030, rq, ak);
         begin
            repeat (5) @(negedge clk);
            chk("enable_low_busy", busy_o, 0);
            enable = 1'b1;
         end
      join
      chk("enable_latency", ak - rq, 8);

      do_req(1'b0, 9'h022, rq, ak);
      chk("full_flag", full_o, 1);
      chk("full_outstanding", outstanding_o, 2);
      chk("full_debug", debug_o[5], 1);
      clr_mon();
      fork
         do_req(1'b0, 9'h023, ts, ta);
         begin
            repeat (10) @(negedge clk);
            chk("full_hold_busy", busy_o, 0);
            chk("full_hold_flag", full_o, 1);
            do_req(1'b1, 9'h030, rs, ra);
         end
      join
      chk("full_release_latency", ra - rs, 5);
      chk("full_trig_after_release", ta - ra, 4);
      chk("full_final_outstanding", outstanding_o, 2);
      chk("full_final_flag", full_o, 1);
      chk("full_last_lock_addr", last_laddr, 9'h023);
      chk("final_lock_unlock_rule", rule_bad, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
